// File: rtl/req_ack_fifo.sv
// Elastic req/ack buffer: pulls words from an upstream producer and serves them
// to a downstream consumer in FIFO order, one outstanding request per side.
module req_ack_fifo #(
  parameter int unsigned data_width = 32,
  parameter int unsigned depth      = 4,
  localparam int unsigned addr_width = $clog2(depth)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  din_req,
  input  logic                  din_ack,
  input  logic [data_width-1:0] din,
  input  logic                  dout_req,
  output logic                  dout_ack,
  output logic [data_width-1:0] dout,
  output logic [addr_width:0]   occupancy,
  output logic [31:0]           count_in,
  output logic [31:0]           count_out
);

  localparam int unsigned occ_width = addr_width + 1;
  localparam logic [occ_width-1:0] full_lvl = occ_width'(depth);

  logic [data_width-1:0] mem_q [depth];

  logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [occ_width-1:0]  occ_q, occ_d;
  logic [31:0]           count_in_q, count_in_d;
  logic [31:0]           count_out_q, count_out_d;
  logic                  din_req_q, din_req_d;
  logic                  dout_ack_q, dout_ack_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic                  push_c, pop_c;

  // Next-state: an ack while full is dropped; a pop never serves a same-edge write
  always_comb begin
    push_c      = din_ack && (occ_q != full_lvl);
    pop_c       = dout_req && !dout_ack_q && (occ_q != '0);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    count_in_d  = count_in_q;
    count_out_d = count_out_q;
    dout_d      = dout_q;
    dout_ack_d  = 1'b0;

    if (push_c) begin
      wr_ptr_d   = wr_ptr_q + addr_width'(1);
      count_in_d = count_in_q + 32'd1;
    end

    if (pop_c) begin
      rd_ptr_d    = rd_ptr_q + addr_width'(1);
      count_out_d = count_out_q + 32'd1;
      dout_d      = mem_q[rd_ptr_q];
      dout_ack_d  = 1'b1;
    end

    case ({push_c, pop_c})
      2'b10:   occ_d = occ_q + occ_width'(1);
      2'b01:   occ_d = occ_q - occ_width'(1);
      default: occ_d = occ_q;
    endcase

    // Drop the request for a cycle after every ack so a held ack is not recounted
    din_req_d = din_ack ? 1'b0 : (occ_d < full_lvl);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      count_in_q  <= '0;
      count_out_q <= '0;
      din_req_q   <= 1'b0;
      dout_ack_q  <= 1'b0;
      dout_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      count_in_q  <= count_in_d;
      count_out_q <= count_out_d;
      din_req_q   <= din_req_d;
      dout_ack_q  <= dout_ack_d;
      dout_q      <= dout_d;
    end
  end

  // Storage needs no reset; contents are only read behind a valid occupancy
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign din_req   = din_req_q;
  assign dout_ack  = dout_ack_q;
  assign dout      = dout_q;
  assign occupancy = occ_q;
  assign count_in  = count_in_q;
  assign count_out = count_out_q;

endmodule

// File: tb/tb_req_ack_fifo.sv
// Directed bench for req_ack_fifo with a random-stall producer/consumer and a
// queue scoreboard of expected output words.
module tb_req_ack_fifo;

  logic        clk;
  logic        rst;
  logic        din_req;
  logic        din_ack;
  logic [31:0] din;
  logic        dout_req;
  logic        dout_ack;
  logic [31:0] dout;
  logic [2:0]  occupancy;
  logic [31:0] count_in;
  logic [31:0] count_out;

  req_ack_fifo #(.data_width(32), .depth(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .din_req   (din_req),
    .din_ack   (din_ack),
    .din       (din),
    .dout_req  (dout_req),
    .dout_ack  (dout_ack),
    .dout      (dout),
    .occupancy (occupancy),
    .count_in  (count_in),
    .count_out (count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          next_val = 0;
  int          prod_limit = 0;
  int unsigned prod_fail = 0;
  int unsigned cons_fail = 0;
  bit          prod_en = 1'b0;
  bit          cons_en = 1'b0;
  bit          spacing_en = 1'b0;
  int          n_acks = 0;
  int          n_out = 0;
  int          cyc = 0;
  int          last_ack = -1;
  int          max_occ = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive producer/consumer, then sample #1 after the edge
  task automatic cycle();
    din_ack = 1'b0;
    if (prod_en && din_req && next_val < prod_limit && $urandom_range(99) >= prod_fail) begin
      chk("ack_not_full", 32'(occupancy < 3'd4), 32'd1);
      din_ack = 1'b1;
      din     = 32'(next_val);
      exp_q.push_back(32'(next_val));
      next_val++;
      n_acks++;
    end
    dout_req = cons_en && ($urandom_range(99) >= cons_fail);
    @(posedge clk);
    #1;
    cyc++;
    if (dout_ack) begin
      if (exp_q.size() == 0) chk("spurious_ack", 32'd1, 32'd0);
      else chk("dout_order", dout, exp_q.pop_front());
      if (spacing_en && last_ack >= 0) chk("ack_spacing", 32'(cyc - last_ack), 32'd2);
      last_ack = cyc;
      n_out++;
    end
    chk("occ_model", 32'(occupancy), 32'(exp_q.size()));
    chk("occ_vs_counts", 32'(occupancy), count_in - count_out);
    if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
  endtask

  // Assert reset between edges, check async clear, release on a negedge
  task automatic do_reset(input bit clear_vals);
    #3;
    din_ack  = 1'b0;
    dout_req = 1'b0;
    rst      = 1'b0;
    #1;
    chk("rst_din_req", 32'(din_req), 32'd0);
    chk("rst_dout_ack", 32'(dout_ack), 32'd0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_count_in", count_in, 32'd0);
    chk("rst_count_out", count_out, 32'd0);
    exp_q.delete();
    n_out = 0;
    n_acks = 0;
    max_occ = 0;
    if (clear_vals) next_val = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("release_din_req", 32'(din_req), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    din_ack = 1'b0;
    din = '0;
    dout_req = 1'b0;

    // Reset held with a toggling ack: nothing may be captured
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      din_ack = ~din_ack;
      @(posedge clk);
      #1;
      chk("hold_din_req", 32'(din_req), 32'd0);
      chk("hold_dout_ack", 32'(dout_ack), 32'd0);
      chk("hold_occ", 32'(occupancy), 32'd0);
      chk("hold_count_in", count_in, 32'd0);
    end
    @(negedge clk);
    din_ack = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("first_din_req", 32'(din_req), 32'd1);

    // Fill with no consumer
    prod_en = 1'b1; prod_fail = 0; prod_limit = 1000; cons_en = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    chk("fill_occ", 32'(occupancy), 32'd4);
    chk("fill_din_req", 32'(din_req), 32'd0);
    chk("fill_count_in", count_in, 32'd4);
    chk("fill_acks", 32'(n_acks), 32'd4);

    // Drain with a continuous consumer
    prod_en = 1'b0; cons_en = 1'b1; cons_fail = 0; spacing_en = 1'b1; last_ack = -1;
    for (int i = 0; i < 40 && n_out < 4; i++) cycle();
    spacing_en = 1'b0;
    chk("drain_done", 32'(n_out), 32'd4);
    chk("drain_occ", 32'(occupancy), 32'd0);
    chk("drain_count_out", count_out, 32'd4);
    chk("drain_din_req", 32'(din_req), 32'd1);

    // Long stream through the wrapping pointers
    do_reset(1'b1);
    prod_en = 1'b1; prod_fail = 0; prod_limit = 5000; cons_en = 1'b1; cons_fail = 0;
    for (int i = 0; i < 15000 && n_out < 5000; i++) cycle();
    chk("wrap_done", 32'(n_out), 32'd5000);
    chk("wrap_count_in", count_in, 32'd5000);
    chk("wrap_count_out", count_out, 32'd5000);
    chk("wrap_max_occ", 32'(max_occ <= 4), 32'd1);

    // Random stalls on both sides
    do_reset(1'b1);
    prod_fail = 30; cons_fail = 50; prod_limit = 2000;
    for (int i = 0; i < 30000 && n_out < 2000; i++) cycle();
    chk("rand_done", 32'(n_out), 32'd2000);
    chk("rand_count_out", count_out, 32'd2000);
    chk("rand_max_occ", 32'(max_occ <= 4), 32'd1);

    // Reset in the middle of operation with three words stored
    do_reset(1'b1);
    prod_fail = 0; cons_fail = 0; cons_en = 1'b0; prod_limit = 3;
    for (int i = 0; i < 40 && occupancy != 3'd3; i++) cycle();
    chk("mid_occ", 32'(occupancy), 32'd3);
    do_reset(1'b0);
    chk("mid_next_val", 32'(next_val), 32'd3);
    cons_en = 1'b1; prod_limit = next_val + 2;
    for (int i = 0; i < 60 && n_out < 2; i++) cycle();
    chk("mid_done", 32'(n_out), 32'd2);
    chk("mid_count_in", count_in, 32'd2);
    chk("mid_count_out", count_out, 32'd2);
    chk("mid_last_dout", dout, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
